// File: rtl/pot_scan_ctrl_pkg.sv
// Shared types and constants for the slide-pot scan controller.
// Contents: slot enum, FSM state enum, slot-to-A2D-channel table,
// default timing parameters and slot/channel helper functions.
package pot_scan_pkg;

  localparam int unsigned RES_W       = 12;
  localparam int unsigned CHNL_W      = 3;
  localparam int unsigned NUM_SLOTS   = 6;
  localparam int unsigned DEF_GAP_CYC = 8;
  localparam int unsigned DEF_TO_CYC  = 4096;

  typedef enum logic [2:0] {
    SLOT_LP  = 3'd0,
    SLOT_B1  = 3'd1,
    SLOT_B2  = 3'd2,
    SLOT_B3  = 3'd3,
    SLOT_HP  = 3'd4,
    SLOT_VOL = 3'd5
  } slot_e;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // A2D channel wired to each pot, in scan order LP, B1, B2, B3, HP, VOL
  localparam logic [CHNL_W-1:0] SLOT_CHNL [NUM_SLOTS] =
    '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  // Channel lookup with a safe fallback for the two unused slot codes
  function automatic logic [CHNL_W-1:0] slot_chnl(input slot_e s);
    logic [CHNL_W-1:0] c;
    c = SLOT_CHNL[0];
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (int'(s) == i) c = SLOT_CHNL[i];
    end
    return c;
  endfunction

  // Round-robin successor: VOL wraps back to LP
  function automatic slot_e next_slot(input slot_e s);
    return (s == SLOT_VOL) ? SLOT_LP : slot_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/pot_scan_ctrl_if.sv
// A2D converter handshake between the scan controller and the A2D master.
//   strt_cnv  : one-cycle conversion request (controller -> A2D)
//   chnl      : channel select, held until cnv_cmplt (controller -> A2D)
//   cnv_cmplt : one-cycle completion pulse, res valid same cycle (A2D -> controller)
//   res       : conversion result (A2D -> controller)
// master = scan controller side, slave = A2D side.
interface pot_scan_ctrl_if;
  import pot_scan_pkg::*;

  logic              strt_cnv;
  logic [CHNL_W-1:0] chnl;
  logic              cnv_cmplt;
  logic [RES_W-1:0]  res;

  modport master (output strt_cnv, output chnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnl, output cnv_cmplt, output res);
endinterface

// File: rtl/pot_scan_ctrl_smooth.sv
// pot_smooth: one latched pot word.
// Ports: clk, rst_n (async active-low), ld (load strobe), res (new sample),
//        val (registered pot word).
// Build option POT_FILT_EN: first load after reset takes res directly, later
// loads apply new = old + ((res - old) >>> 2), clamped to [0, 2^RES_W-1].
module pot_smooth
  import pot_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [RES_W-1:0] res,
  output logic [RES_W-1:0] val
);

  logic [RES_W-1:0] val_q, val_d;

`ifdef POT_FILT_EN
  localparam int unsigned EXT_W = RES_W + 1;

  logic                    seeded_q, seeded_d;
  logic signed [EXT_W-1:0] diff_c, step_c, sum_c;
  logic [RES_W-1:0]        filt_c;

  // Smoother step in RES_W+1 signed arithmetic; floor shift keeps sum between old and res
  always_comb begin
    diff_c = $signed({1'b0, res}) - $signed({1'b0, val_q});
    step_c = diff_c >>> 2;
    sum_c  = $signed({1'b0, val_q}) + step_c;
    // Any non-negative EXT_W-bit value already fits in RES_W bits, so only the low side clamps
    if (sum_c[EXT_W-1]) filt_c = '0;
    else                filt_c = sum_c[RES_W-1:0];
  end

  // Next value: unseeded slot loads raw, seeded slot loads filtered
  always_comb begin
    val_d    = val_q;
    seeded_d = seeded_q;
    if (ld) begin
      val_d    = seeded_q ? filt_c : res;
      seeded_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= '0;
      seeded_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      seeded_q <= seeded_d;
    end
  end
`else
  // Plain latch of the conversion result
  always_comb begin
    val_d = val_q;
    if (ld) val_d = res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end
`endif

  assign val = val_q;

endmodule

// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: round-robin sequencer for the slide-pot A2D converter.
// Ports: clk, rst_n (async active-low); a2d (pot_scan_ctrl_if.master:
//        strt_cnv, chnl out / cnv_cmplt, res in); POT_LP..POT_VOL latched
//        pot words; scan_done (pulse on VOL latch); pots_valid (sticky after
//        first full scan); to_err (pulse on conversion timeout).
// Build option POT_FILT_EN enables the per-pot smoother in pot_smooth.
module pot_scan_ctrl
  import pot_scan_pkg::*;
#(
  parameter int unsigned GAP_CYC = DEF_GAP_CYC,
  parameter int unsigned TO_CYC  = DEF_TO_CYC
)(
  input  logic             clk,
  input  logic             rst_n,
  pot_scan_ctrl_if.master  a2d,
  output logic [RES_W-1:0] POT_LP,
  output logic [RES_W-1:0] POT_B1,
  output logic [RES_W-1:0] POT_B2,
  output logic [RES_W-1:0] POT_B3,
  output logic [RES_W-1:0] POT_HP,
  output logic [RES_W-1:0] POT_VOL,
  output logic             scan_done,
  output logic             pots_valid,
  output logic             to_err
);

  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam int unsigned TO_W  = $clog2(TO_CYC);

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  slot_e             slot_q, slot_d;
  logic [CHNL_W-1:0] chnl_q, chnl_d;
  logic              strt_cnv_q, strt_cnv_d;
  logic              scan_done_q, scan_done_d;
  logic              pots_valid_q, pots_valid_d;
  logic              to_err_q, to_err_d;
  logic              cmplt_c;
  logic [NUM_SLOTS-1:0] ld_c;
  logic [RES_W-1:0]  pot_val [NUM_SLOTS];

  // Completion is only honoured while a conversion is outstanding
  assign cmplt_c = (state_q == ST_WAIT) && a2d.cnv_cmplt;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    slot_d       = slot_q;
    chnl_d       = chnl_q;
    strt_cnv_d   = 1'b0;
    scan_done_d  = 1'b0;
    pots_valid_d = pots_valid_q;
    to_err_d     = 1'b0;

    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          state_d    = ST_START;
          gap_cnt_d  = '0;
          strt_cnv_d = 1'b1;
          chnl_d     = slot_chnl(slot_q);
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_START: begin
        state_d  = ST_WAIT;
        to_cnt_d = '0;
      end
      ST_WAIT: begin
        if (cmplt_c) begin
          // Completion beats a coincident timeout
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          slot_d    = next_slot(slot_q);
          if (slot_q == SLOT_VOL) begin
            scan_done_d  = 1'b1;
            pots_valid_d = 1'b1;
          end
        end else if (to_cnt_q == TO_W'(TO_CYC - 2)) begin
          // Counter reaching TO_CYC-1 on this edge lands to_err TO_CYC clocks after strt_cnv;
          // slot is held so the same channel is retried
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          to_err_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
    endcase
  end

  // One-hot load strobe for the slot being completed
  always_comb begin
    ld_c = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      ld_c[i] = cmplt_c && (int'(slot_q) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      gap_cnt_q    <= '0;
      to_cnt_q     <= '0;
      slot_q       <= SLOT_LP;
      chnl_q       <= slot_chnl(SLOT_LP);
      strt_cnv_q   <= 1'b0;
      scan_done_q  <= 1'b0;
      pots_valid_q <= 1'b0;
      to_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      to_cnt_q     <= to_cnt_d;
      slot_q       <= slot_d;
      chnl_q       <= chnl_d;
      strt_cnv_q   <= strt_cnv_d;
      scan_done_q  <= scan_done_d;
      pots_valid_q <= pots_valid_d;
      to_err_q     <= to_err_d;
    end
  end

  // One holding register per pot
  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_pot
    pot_smooth u_pot (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld_c[g]),
      .res   (a2d.res),
      .val   (pot_val[g])
    );
  end

  assign a2d.strt_cnv = strt_cnv_q;
  assign a2d.chnl     = chnl_q;
  assign POT_LP       = pot_val[0];
  assign POT_B1       = pot_val[1];
  assign POT_B2       = pot_val[2];
  assign POT_B3       = pot_val[3];
  assign POT_HP       = pot_val[4];
  assign POT_VOL      = pot_val[5];
  assign scan_done    = scan_done_q;
  assign pots_valid   = pots_valid_q;
  assign to_err       = to_err_q;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Self-checking bench for pot_scan_ctrl: directed sequence with randomized
// results/latencies, checked against a slot-level model of the scan.
module tb_pot_scan_ctrl;
  import pot_scan_pkg::*;

  localparam int unsigned GAPC = DEF_GAP_CYC;
  localparam int unsigned TOC  = DEF_TO_CYC;

  logic clk = 1'b0;
  logic rst_n;
  logic [RES_W-1:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol;
  logic scan_done, pots_valid, to_err;

  pot_scan_ctrl_if a2d ();

  pot_scan_ctrl #(.GAP_CYC(GAPC), .TO_CYC(TOC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a2d        (a2d),
    .POT_LP     (pot_lp),
    .POT_B1     (pot_b1),
    .POT_B2     (pot_b2),
    .POT_B3     (pot_b3),
    .POT_HP     (pot_hp),
    .POT_VOL    (pot_vol),
    .scan_done  (scan_done),
    .pots_valid (pots_valid),
    .to_err     (to_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tbl [6] = '{1, 0, 4, 2, 3, 7};
  logic [11:0] fixed_vals [6] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'hFFF};
  logic [11:0] m_pot [6];
  bit          m_seed [6];
  int          m_slot;
  bit          m_valid;
  int          skew;

`ifdef POT_FILT_EN
  logic [11:0] lp_in  [4] = '{12'h800, 12'h000, 12'h000, 12'h000};
  logic [11:0] lp_exp [4] = '{12'h800, 12'h600, 12'h480, 12'h360};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pot_of(input int s);
    case (s)
      0:       return pot_lp;
      1:       return pot_b1;
      2:       return pot_b2;
      3:       return pot_b3;
      4:       return pot_hp;
      default: return pot_vol;
    endcase
  endfunction

  // Value a pot register should hold after loading nv on top of old
  function automatic logic [11:0] model_ld(input logic [11:0] old, input logic [11:0] nv,
                                           input bit seeded);
`ifdef POT_FILT_EN
    if (seeded) begin
      int d;
      int r;
      d = int'(nv) - int'(old);
      r = int'(old) + (d >>> 2);
      if (r < 0) r = 0;
      if (r > 4095) r = 4095;
      return 12'(r);
    end
`else
    if (seeded) return nv;
`endif
    return nv;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 6; s++) begin
      m_pot[s]  = '0;
      m_seed[s] = 1'b0;
    end
    m_slot  = 0;
    m_valid = 1'b0;
  endtask

  task automatic chk_pots(input string tag);
    for (int s = 0; s < 6; s++) chk($sformatf("%s_pot%0d", tag, s), 32'(pot_of(s)), 32'(m_pot[s]));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_pots(tag);
    chk({tag, "_strt"},  32'(a2d.strt_cnv), 32'd0);
    chk({tag, "_chnl"},  32'(a2d.chnl), 32'd1);
    chk({tag, "_done"},  32'(scan_done), 32'd0);
    chk({tag, "_valid"}, 32'(pots_valid), 32'd0);
    chk({tag, "_toerr"}, 32'(to_err), 32'd0);
  endtask

  // Wait (bounded) for strt_cnv; checks gap length and channel
  task automatic wait_strt();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a2d.strt_cnv !== 1'b1 && n < 400);
    chk("gap_len", 32'(n), 32'(GAPC - skew));
    chk("chnl", 32'(a2d.chnl), 32'(tbl[m_slot]));
    skew = 0;
  endtask

  // One conversion: optional spurious pulse in GAP, then answer after lat clocks or drop it
  task automatic conv(input bit drop, input bit spur, input int lat, input logic [11:0] v);
    int s;
    int first;
    bit stable;
    if (spur) begin
      repeat (2) @(negedge clk);
      a2d.cnv_cmplt = 1'b1;
      a2d.res       = 12'h0AA;
      @(negedge clk);
      a2d.cnv_cmplt = 1'b0;
      chk_pots("spur");
      skew = 3;
    end
    wait_strt();
    s = m_slot;
    @(negedge clk);
    chk("strt_1cyc", 32'(a2d.strt_cnv), 32'd0);
    if (!drop) begin
      stable = 1'b1;
      for (int k = 2; k < lat; k++) begin
        @(negedge clk);
        if (a2d.chnl !== 3'(tbl[s])) stable = 1'b0;
      end
      chk("chnl_stable", 32'(stable), 32'd1);
      a2d.cnv_cmplt = 1'b1;
      a2d.res       = v;
      @(negedge clk);
      a2d.cnv_cmplt = 1'b0;
      a2d.res       = 12'($urandom);
      m_pot[s]  = model_ld(m_pot[s], v, m_seed[s]);
      m_seed[s] = 1'b1;
      m_slot    = (s + 1) % 6;
      if (s == 5) m_valid = 1'b1;
      chk("scan_done", 32'(scan_done), 32'(s == 5));
      chk("pots_valid", 32'(pots_valid), 32'(m_valid));
      chk("to_err_idle", 32'(to_err), 32'd0);
      chk_pots("conv");
    end else begin
      first = 0;
      for (int k = 2; k <= int'(TOC) + 4 && first == 0; k++) begin
        @(negedge clk);
        if (to_err === 1'b1) first = k;
      end
      chk("to_delay", 32'(first), 32'(TOC));
      chk_pots("drop");
      @(negedge clk);
      chk("to_err_1cyc", 32'(to_err), 32'd0);
      skew = 1;
    end
  endtask

  task automatic rand_scan();
    for (int s = 0; s < 6; s++) conv(1'b0, 1'b0, int'($urandom_range(40, 2)), 12'($urandom));
  endtask

  initial begin
    a2d.cnv_cmplt = 1'b0;
    a2d.res       = '0;
    rst_n         = 1'b0;
    skew          = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Scan 1: distinct fixed values, A2D answers 20 clocks after strt_cnv
    for (int s = 0; s < 6; s++) conv(1'b0, 1'b0, 20, fixed_vals[s]);

    // Scan 2: B2 dropped once then retried; spurious pulse before HP
    for (int s = 0; s < 6; s++) begin
      if (s == 2) conv(1'b1, 1'b0, 0, 12'h000);
      conv(1'b0, (s == 4), int'($urandom_range(40, 2)), 12'($urandom));
    end

    // Scan 3: random
    rand_scan();

    // Reset while waiting on slot 3 (B3)
    for (int s = 0; s < 3; s++) conv(1'b0, 1'b0, int'($urandom_range(40, 2)), 12'($urandom));
    wait_strt();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    a2d.cnv_cmplt = 1'b1;
    a2d.res       = 12'h555;
    @(negedge clk);
    a2d.cnv_cmplt = 1'b0;
    chk_pots("late_cmplt");
    chk("late_valid", 32'(pots_valid), 32'd0);
    skew = 3;

`ifdef POT_FILT_EN
    // Smoother step response on LP, then saturation toward full scale
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 6; s++) begin
        conv(1'b0, 1'b0, int'($urandom_range(40, 2)), (s == 0) ? lp_in[i] : 12'($urandom));
        if (s == 0) chk("filt_lp", 32'(pot_lp), 32'(lp_exp[i]));
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 6; s++) conv(1'b0, 1'b0, 4, (s == 0) ? 12'hFFF : 12'($urandom));
    end
`else
    rand_scan();
`endif
    rand_scan();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
